// File: rtl/cp_sequencer_40.sv
// -----------------------------------------------------------------------------
// cp_sequencer_40
// Command sequencer placed directly in front of the 40-bit cryptoprocessor.
// Host requests (data write, instruction exec, result read) are queued in a
// FIFO. They are then replayed one at a time onto the processor pins. Each
// instruction's fixed latency is counted out before the next request goes.
// Read results are returned on a valid/ready port.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready      host request handshake (push when both high)
//   req_tag                  00 write, 01 exec, 10 read, 11 reserved
//   req_cmd                  24-bit command word, [23:21] = INS
//   req_d1/req_d2            40-bit operand halves for writes
//   res_valid/res_ready      read result handshake
//   res_d1/res_d2            read result halves
//   busy                     work queued or in progress
//   err                      sticky, a reserved tag was popped
//   cp_command               to command_cp (held between execs)
//   cp_data_en/cp_ins_in/cp_get_output   one-cycle strobes to the processor
//   cp_din_1/cp_din_2        to din_1/din_2 (held between writes)
//   cp_dout_1/cp_dout_2      from dout_1/dout_2
// -----------------------------------------------------------------------------
module cp_sequencer_40 #(
    parameter int DEPTH   = 8,
    parameter int LAT_ADD = 2,
    parameter int LAT_SUB = 2,
    parameter int LAT_MUL = 6,
    parameter int LAT_DEF = 1,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_tag,
    input  logic [23:0] req_cmd,
    input  logic [39:0] req_d1,
    input  logic [39:0] req_d2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [39:0] res_d1,
    output logic [39:0] res_d2,
    output logic        busy,
    output logic        err,
    output logic [23:0] cp_command,
    output logic        cp_data_en,
    output logic        cp_ins_in,
    output logic        cp_get_output,
    output logic [39:0] cp_din_1,
    output logic [39:0] cp_din_2,
    input  logic [39:0] cp_dout_1,
    input  logic [39:0] cp_dout_2
);

    localparam int AW = $clog2(DEPTH);
    // The wait counter is 8 bits wide, so latencies up to 255 cycles are supported.
    localparam int CW = 8;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] TAG_WR = 2'b00;
    localparam logic [1:0] TAG_EX = 2'b01;
    localparam logic [1:0] TAG_RD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_EX    = 3'd2,
        S_WAIT  = 3'd3,
        S_RD    = 3'd4,
        S_RWAIT = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    // Maps an instruction code to the number of wait cycles after its issue.
    function automatic logic [CW-1:0] lat_of(input logic [2:0] ins);
        logic [CW-1:0] l;
        case (ins)
            3'd1:    l = CW'(LAT_ADD);
            3'd2:    l = CW'(LAT_SUB);
            3'd3:    l = CW'(LAT_MUL);
            default: l = CW'(LAT_DEF);
        endcase
        return l;
    endfunction

    // FIFO storage and bookkeeping
    logic [1:0]    tag_mem [DEPTH];
    logic [23:0]   cmd_mem [DEPTH];
    logic [39:0]   d1_mem  [DEPTH];
    logic [39:0]   d2_mem  [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          push_s;
    logic          pop_s;

    logic [1:0]    head_tag_s;
    logic [23:0]   head_cmd_s;
    logic [39:0]   head_d1_s;
    logic [39:0]   head_d2_s;

    // Sequencer state and registered outputs
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          err_r, err_s;
    logic          req_ready_r;
    logic          busy_r;
    logic          res_valid_r, res_valid_s;
    logic [39:0]   res_d1_r, res_d1_s;
    logic [39:0]   res_d2_r, res_d2_s;
    logic [23:0]   cp_command_r, cp_command_s;
    logic          cp_data_en_r, cp_data_en_s;
    logic          cp_ins_in_r, cp_ins_in_s;
    logic          cp_get_output_r, cp_get_output_s;
    logic [39:0]   cp_din_1_r, cp_din_1_s;
    logic [39:0]   cp_din_2_r, cp_din_2_s;

    // A push is gated by the registered ready so a full FIFO can never be overwritten.
    assign push_s = req_valid && req_ready_r;

    assign head_tag_s = tag_mem[rd_ptr_r];
    assign head_cmd_s = cmd_mem[rd_ptr_r];
    assign head_d1_s  = d1_mem[rd_ptr_r];
    assign head_d2_s  = d2_mem[rd_ptr_r];

    // FIFO payload write (storage needs no reset, pointers define validity)
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem[wr_ptr_r] <= req_tag;
            cmd_mem[wr_ptr_r] <= req_cmd;
            d1_mem[wr_ptr_r]  <= req_d1;
            d2_mem[wr_ptr_r]  <= req_d2;
        end
    end

    // Next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 1'b1;
            2'b01:   count_s = count_r - 1'b1;
            default: count_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and the registered ready/busy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r     <= count_s;
            req_ready_r <= (count_s != FULL_CNT);
            busy_r      <= (state_s != S_IDLE) || (count_s != '0);
        end
    end

    // Next-state and next-output logic of the replay FSM
    always_comb begin
        state_s         = state_r;
        cnt_s           = cnt_r;
        err_s           = err_r;
        pop_s           = 1'b0;
        res_valid_s     = res_valid_r;
        res_d1_s        = res_d1_r;
        res_d2_s        = res_d2_r;
        cp_command_s    = cp_command_r;
        cp_data_en_s    = 1'b0;
        cp_ins_in_s     = 1'b0;
        cp_get_output_s = 1'b0;
        cp_din_1_s      = cp_din_1_r;
        cp_din_2_s      = cp_din_2_r;
        case (state_r)
            S_IDLE: begin
                if (count_r != '0) begin
                    pop_s = 1'b1;
                    // Strobes are loaded on the dispatch edge so they are
                    // high exactly while the FSM sits in the action state.
                    case (head_tag_s)
                        TAG_WR: begin
                            state_s      = S_WR;
                            cp_data_en_s = 1'b1;
                            cp_din_1_s   = head_d1_s;
                            cp_din_2_s   = head_d2_s;
                        end
                        TAG_EX: begin
                            state_s      = S_EX;
                            cnt_s        = lat_of(head_cmd_s[23:21]);
                            cp_ins_in_s  = 1'b1;
                            cp_command_s = head_cmd_s;
                        end
                        TAG_RD: begin
                            state_s         = S_RD;
                            cnt_s           = CW'(RD_LAT);
                            cp_get_output_s = 1'b1;
                        end
                        default: begin
                            // Reserved tag: dropped without touching the processor.
                            err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR: begin
                state_s = S_IDLE;
            end
            S_EX: begin
                if (cnt_r == 8'd0) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_r <= 8'd1) begin
                    cnt_s   = 8'd0;
                    state_s = S_IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            S_RD: begin
                state_s = S_RWAIT;
            end
            S_RWAIT: begin
                // The last counted cycle is the one in which dout is valid.
                if (cnt_r <= 8'd1) begin
                    cnt_s       = 8'd0;
                    res_valid_s = 1'b1;
                    res_d1_s    = cp_dout_1;
                    res_d2_s    = cp_dout_2;
                    state_s     = S_RESP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            S_RESP: begin
                if (res_valid_r && res_ready) begin
                    res_valid_s = 1'b0;
                    res_d1_s    = 40'd0;
                    res_d2_s    = 40'd0;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and all registered processor/host outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_IDLE;
            cnt_r           <= '0;
            err_r           <= 1'b0;
            res_valid_r     <= 1'b0;
            res_d1_r        <= '0;
            res_d2_r        <= '0;
            cp_command_r    <= '0;
            cp_data_en_r    <= 1'b0;
            cp_ins_in_r     <= 1'b0;
            cp_get_output_r <= 1'b0;
            cp_din_1_r      <= '0;
            cp_din_2_r      <= '0;
        end else begin
            state_r         <= state_s;
            cnt_r           <= cnt_s;
            err_r           <= err_s;
            res_valid_r     <= res_valid_s;
            res_d1_r        <= res_d1_s;
            res_d2_r        <= res_d2_s;
            cp_command_r    <= cp_command_s;
            cp_data_en_r    <= cp_data_en_s;
            cp_ins_in_r     <= cp_ins_in_s;
            cp_get_output_r <= cp_get_output_s;
            cp_din_1_r      <= cp_din_1_s;
            cp_din_2_r      <= cp_din_2_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign res_valid     = res_valid_r;
    assign res_d1        = res_d1_r;
    assign res_d2        = res_d2_r;
    assign cp_command    = cp_command_r;
    assign cp_data_en    = cp_data_en_r;
    assign cp_ins_in     = cp_ins_in_r;
    assign cp_get_output = cp_get_output_r;
    assign cp_din_1      = cp_din_1_r;
    assign cp_din_2      = cp_din_2_r;

endmodule
